// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port byte RAM.
// Each granted access spends one BUSY cycle on the RAM; ack and read data are registered.
module ram_arbiter #(
   parameter int bus_addr_data_width = 13
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           m0_req,
   input  logic                           m0_we,
   input  logic [bus_addr_data_width-1:0] m0_a,
   input  logic [7:0]                     m0_w,
   output logic                           m0_ack,
   output logic [7:0]                     m0_r,
   input  logic                           m1_req,
   input  logic                           m1_we,
   input  logic [bus_addr_data_width-1:0] m1_a,
   input  logic [7:0]                     m1_w,
   output logic                           m1_ack,
   output logic [7:0]                     m1_r,
   output logic                           dmem_we,
   output logic                           dmem_re,
   output logic [bus_addr_data_width-1:0] dmem_a,
   output logic [7:0]                     dmem_w,
   input  logic [7:0]                     dmem_r
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic       m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
   logic [7:0] m0_r_q, m0_r_d, m1_r_q, m1_r_d;
   logic       elig0, elig1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_r_q   <= 8'h00;
         m1_r_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         m0_ack_q <= m0_ack_d;
         m1_ack_q <= m1_ack_d;
         m0_r_q   <= m0_r_d;
         m1_r_q   <= m1_r_d;
      end
   end

   // A master in its ack cycle is still holding req for the access just finished.
   assign elig0 = m0_req & ~m0_ack_q;
   assign elig1 = m1_req & ~m1_ack_q;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      m0_ack_d = 1'b0;
      m1_ack_d = 1'b0;
      m0_r_d   = m0_r_q;
      m1_r_d   = m1_r_q;
      case (state_q)
         IDLE: begin
            if (elig0 && (!elig1 || last_q)) begin
               state_d = BUSY0;
               last_d  = 1'b0;
            end else if (elig1) begin
               state_d = BUSY1;
               last_d  = 1'b1;
            end
         end
         BUSY0: begin
            state_d  = IDLE;
            m0_ack_d = 1'b1;
            if (!m0_we) m0_r_d = dmem_r;
         end
         BUSY1: begin
            state_d  = IDLE;
            m1_ack_d = 1'b1;
            if (!m1_we) m1_r_d = dmem_r;
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM port is a pure decode of state, so reset silences it immediately.
   always_comb begin
      dmem_we = 1'b0;
      dmem_re = 1'b0;
      dmem_a  = '0;
      dmem_w  = 8'h00;
      case (state_q)
         BUSY0: begin
            dmem_we = m0_we;
            dmem_re = ~m0_we;
            dmem_a  = m0_a;
            dmem_w  = m0_w;
         end
         BUSY1: begin
            dmem_we = m1_we;
            dmem_re = ~m1_we;
            dmem_a  = m1_a;
            dmem_w  = m1_w;
         end
         default: ;
      endcase
   end

   assign m0_ack = m0_ack_q;
   assign m1_ack = m1_ack_q;
   assign m0_r   = m0_r_q;
   assign m1_r   = m1_r_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed master sequences push expected acks,
// a negedge monitor pops and compares master, cycle and read data.
module tb_ram_arbiter;
   localparam int AW = 13;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_a, m1_a;
   logic [7:0]    m0_w, m1_w;
   logic          m0_ack, m1_ack;
   logic [7:0]    m0_r, m1_r;
   logic          dmem_we, dmem_re;
   logic [AW-1:0] dmem_a;
   logic [7:0]    dmem_w, dmem_r;

   ram_arbiter #(.bus_addr_data_width(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_w(m0_w), .m0_ack(m0_ack), .m0_r(m0_r),
      .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_w(m1_w), .m1_ack(m1_ack), .m1_r(m1_r),
      .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_a(dmem_a), .dmem_w(dmem_w), .dmem_r(dmem_r)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: write on the edge, combinational read.
   logic [7:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) mem[i] <= (i == (1<<AW)-1) ? 8'h3C : 8'h00;
   always @(posedge clk) if (dmem_we) mem[dmem_a] <= dmem_w;
   assign dmem_r = dmem_re ? mem[dmem_a] : 8'h00;

   typedef struct {
      int         m;
      logic [7:0] r;
      int         cyc;
   } exp_t;
   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model_r [2];
   int         n_cmp = 0;
   int         n_err = 0;

   logic          op_we [2][8];
   logic [AW-1:0] op_a  [2][8];
   logic [7:0]    op_w  [2][8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic expect_ack(input int m, input logic we, input logic [7:0] rd, input int c);
      exp_t e;
      if (!we) model_r[m] = rd;
      e.m   = m;
      e.r   = model_r[m];
      e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic set_op(input int m, input int i, input logic we, input logic [AW-1:0] a,
                         input logic [7:0] w);
      op_we[m][i] = we;
      op_a[m][i]  = a;
      op_w[m][i]  = w;
   endtask

   task automatic drive(input int m, input logic req, input logic we, input logic [AW-1:0] a,
                        input logic [7:0] w);
      if (m == 0) begin
         m0_req = req; m0_we = we; m0_a = a; m0_w = w;
      end else begin
         m1_req = req; m1_we = we; m1_a = a; m1_w = w;
      end
   endtask

   // Hold req across consecutive accesses, changing operands right after each ack cycle.
   task automatic m_seq(input int m, input int n);
      for (int i = 0; i < n; i++) begin
         int   t;
         logic got;
         drive(m, 1'b1, op_we[m][i], op_a[m][i], op_w[m][i]);
         t   = 0;
         got = 1'b0;
         while (!got && t < 40) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
            t++;
         end
         if (!got) chk($sformatf("ack_timeout_m%0d_op%0d", m, i), {31'd0, got}, 1);
         @(posedge clk);
         #1;
      end
      drive(m, 1'b0, op_we[m][n-1], op_a[m][n-1], op_w[m][n-1]);
   endtask

   task automatic start(output int k);
      repeat (2) @(posedge clk);
      #1;
      k = cyc;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m0_ack || m1_ack) begin
            chk("dual_ack", {31'd0, m0_ack & m1_ack}, 0);
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_ack: m0_ack=%0d m1_ack=%0d at cycle %0d, expected none",
                        m0_ack, m1_ack, cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("ack_master", m1_ack ? 1 : 0, mon_e.m);
               chk("ack_cycle", cyc, mon_e.cyc);
               chk("ack_rdata", {24'd0, (mon_e.m == 1) ? m1_r : m0_r}, {24'd0, mon_e.r});
            end
         end
         if (dmem_we || dmem_re) chk("we_re_exclusive", {31'd0, dmem_we & dmem_re}, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, '0, 8'h00);
      drive(1, 1'b0, 1'b0, '0, 8'h00);
      model_r[0] = 8'h00;
      model_r[1] = 8'h00;

      @(negedge clk);
      chk("rst_m0_ack", {31'd0, m0_ack}, 0);
      chk("rst_m1_ack", {31'd0, m1_ack}, 0);
      chk("rst_m0_r", {24'd0, m0_r}, 0);
      chk("rst_m1_r", {24'd0, m1_r}, 0);
      chk("rst_dmem_we", {31'd0, dmem_we}, 0);
      chk("rst_dmem_re", {31'd0, dmem_re}, 0);
      chk("rst_dmem_a", {19'd0, dmem_a}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Simultaneous first requests: m0 wins the first tie, m1 two cycles later.
      start(k);
      set_op(0, 0, 1'b1, 13'h0005, 8'h77);
      set_op(1, 0, 1'b1, 13'h0006, 8'h88);
      expect_ack(0, 1'b1, 8'h00, k + 2);
      expect_ack(1, 1'b1, 8'h00, k + 4);
      fork
         m_seq(0, 1);
         m_seq(1, 1);
      join

      // Both masters back-to-back: strict alternation, one ack every 2 cycles.
      start(k);
      set_op(0, 0, 1'b1, 13'h0020, 8'h11);
      set_op(0, 1, 1'b1, 13'h0021, 8'h22);
      set_op(0, 2, 1'b0, 13'h0020, 8'h00);
      set_op(0, 3, 1'b0, 13'h0021, 8'h00);
      set_op(1, 0, 1'b1, 13'h0030, 8'h33);
      set_op(1, 1, 1'b0, 13'h0020, 8'h00);
      set_op(1, 2, 1'b0, 13'h0030, 8'h00);
      set_op(1, 3, 1'b0, 13'h0021, 8'h00);
      expect_ack(0, 1'b1, 8'h00, k + 2);
      expect_ack(1, 1'b1, 8'h00, k + 4);
      expect_ack(0, 1'b1, 8'h00, k + 6);
      expect_ack(1, 1'b0, 8'h11, k + 8);
      expect_ack(0, 1'b0, 8'h11, k + 10);
      expect_ack(1, 1'b0, 8'h33, k + 12);
      expect_ack(0, 1'b0, 8'h22, k + 14);
      expect_ack(1, 1'b0, 8'h22, k + 16);
      fork
         m_seq(0, 4);
         m_seq(1, 4);
      join

      // Single master write then read-back of the same byte.
      start(k);
      set_op(0, 0, 1'b1, 13'h0010, 8'hA5);
      set_op(0, 1, 1'b0, 13'h0010, 8'h00);
      expect_ack(0, 1'b1, 8'h00, k + 2);
      expect_ack(0, 1'b0, 8'hA5, k + 5);
      m_seq(0, 2);

      // Top-address read by m1 (last grant was m0) racing an address-0 write by m0.
      start(k);
      set_op(0, 0, 1'b1, 13'h0000, 8'h5A);
      set_op(1, 0, 1'b0, 13'h1FFF, 8'h00);
      expect_ack(1, 1'b0, 8'h3C, k + 2);
      expect_ack(0, 1'b1, 8'h00, k + 4);
      fork
         m_seq(0, 1);
         m_seq(1, 1);
         begin
            repeat (2) @(negedge clk);
            chk("top_dmem_a", {19'd0, dmem_a}, 32'h1FFF);
            chk("top_dmem_re", {31'd0, dmem_re}, 1);
            repeat (2) @(negedge clk);
            chk("zero_dmem_a", {19'd0, dmem_a}, 0);
            chk("zero_dmem_we", {31'd0, dmem_we}, 1);
            chk("zero_dmem_w", {24'd0, dmem_w}, 32'h5A);
         end
      join

      // req held through the ack cycle then dropped: exactly one access.
      start(k);
      set_op(0, 0, 1'b1, 13'h0040, 8'h99);
      expect_ack(0, 1'b1, 8'h00, k + 2);
      m_seq(0, 1);
      repeat (6) @(posedge clk);
      chk("single_access_drained", sb.size(), 0);

      // Reset in the middle of a BUSY0 write aborts it without an ack.
      start(k);
      drive(0, 1'b1, 1'b1, 13'h0050, 8'hFF);
      repeat (2) @(negedge clk);
      chk("busy0_dmem_we", {31'd0, dmem_we}, 1);
      chk("busy0_dmem_w", {24'd0, dmem_w}, 32'hFF);
      #1 rst = 1'b1;
      #1;
      chk("abort_dmem_we", {31'd0, dmem_we}, 0);
      chk("abort_dmem_a", {19'd0, dmem_a}, 0);
      chk("abort_dmem_w", {24'd0, dmem_w}, 0);
      chk("abort_m0_r", {24'd0, m0_r}, 0);
      chk("abort_m1_r", {24'd0, m1_r}, 0);
      chk("abort_m0_ack", {31'd0, m0_ack}, 0);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b1, 13'h0050, 8'hFF);
      @(negedge clk);
      chk("abort_no_ack", {31'd0, m0_ack}, 0);
      rst = 1'b0;
      model_r[0] = 8'h00;
      model_r[1] = 8'h00;

      // Normal service resumes after reset.
      start(k);
      set_op(1, 0, 1'b0, 13'h0010, 8'h00);
      expect_ack(1, 1'b0, 8'hA5, k + 2);
      m_seq(1, 1);
      repeat (4) @(posedge clk);
      chk("final_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter bus_addr_data_width, default 13, meaning the byte address width of the data RAM.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports m0_req, m1_req, input, 1 bit each: master access request, level, held until the matching ack.
REQ-005 The block SHALL have ports m0_we, m1_we, input, 1 bit each: 1 = write, 0 = read; held stable while req is high.
REQ-006 The block SHALL have ports m0_a, m1_a, input, bus_addr_data_width bits each: byte address; held stable while req is high.
REQ-007 The block SHALL have ports m0_w, m1_w, input, 8 bits each: write data; held stable while req is high.
REQ-008 The block SHALL have ports m0_ack, m1_ack, output, 1 bit each: one-cycle completion pulse, registered.
REQ-009 The block SHALL have ports m0_r, m1_r, output, 8 bits each: registered read data, valid from the ack cycle until that master's next read completes.
REQ-010 The block SHALL have ports dmem_we, dmem_re, output, 1 bit each: RAM write and read enables.
REQ-011 The block SHALL have port dmem_a, output, bus_addr_data_width bits: RAM address.
REQ-012 The block SHALL have port dmem_w, output, 8 bits: RAM write data.
REQ-013 The block SHALL have port dmem_r, input, 8 bits: RAM combinational read data; high-Z when dmem_re is low.

Function
REQ-014 The block SHALL implement the states IDLE, BUSY0 and BUSY1, plus a 1-bit round-robin register last, holding the last granted master.
REQ-015 In IDLE, a master is eligible when its req=1 and its ack=0 in the same cycle; the ack=0 condition masks the request a master is still dropping.
REQ-016 In IDLE with exactly one master eligible, the next state SHALL be BUSYx for that master.
REQ-017 In IDLE with both masters eligible, the block SHALL grant the master != last; the next state SHALL be BUSYx and last SHALL become x.
REQ-018 In BUSYx the block SHALL drive the RAM port combinationally from master x: dmem_a=mx_a, dmem_w=mx_w, dmem_we=mx_we, dmem_re=~mx_we.
REQ-019 In IDLE the block SHALL drive dmem_we=0, dmem_re=0, dmem_a=0 and dmem_w=0.
REQ-020 On the clock edge that ends BUSYx, the block SHALL set mx_ack=1 for exactly one cycle and move to IDLE.
REQ-021 On that same edge, for a read (mx_we=0), the block SHALL load mx_r from dmem_r; for a write, mx_r SHALL be unchanged.
REQ-022 The RAM write SHALL occur on the edge ending BUSYx; a read of the same address in a later access SHALL return the new data.
REQ-023 Access latency SHALL be: request seen in IDLE at edge N, BUSY during cycle N+1, ack during cycle N+2; peak throughput is 1 access per 2 cycles.
REQ-024 The block SHALL never assert both acks in one cycle, and SHALL never assert dmem_we and dmem_re together.
REQ-025 If req drops during BUSYx (a protocol violation), the block SHALL still complete the access and issue the ack.
REQ-026 A master SHALL NOT be granted twice in a row while the other is continuously eligible, so the wait before grant is bounded by one foreign access.

Reset
REQ-027 While rst=1, the block SHALL asynchronously force: state=IDLE, last=1 (m0 wins the first tie), m0_ack=m1_ack=0, m0_r=m1_r=8'h00.
REQ-028 Because dmem_* are decoded from state, they SHALL read 0 immediately on reset.
REQ-029 If rst asserts during BUSYx, the access SHALL be aborted with no ack issued; the RAM write is not guaranteed.
REQ-030 After rst is released, the block SHALL sample requests normally from the first rising edge.

Verification
REQ-031 m0 writes 8'hA5 to 13'h0010, then reads 13'h0010 -> m0_ack pulses 2 cycles after each request edge, and m0_r=8'hA5 after the second ack.
REQ-032 m0 and m1 raise req in the same cycle straight after reset -> m0 is granted first; m1's ack follows 2 cycles after m0's ack.
REQ-033 m0 and m1 both hold requests continuously for 4 accesses each -> grants alternate m0, m1, m0, m1, ...; both acks never high together.
REQ-034 m1 reads 13'h1FFF (top address) holding 8'h3C while m0 writes 13'h0000 -> m1_r=8'h3C, m0_r unchanged, dmem_a wraps to neither out-of-range value.
REQ-035 rst pulses mid-BUSY0 on a write of 8'hFF -> no m0_ack, dmem_we=0 at once, state IDLE, both m_r=8'h00.
REQ-036 Hold m0_req high during its ack cycle, then drop it -> exactly one access occurs, with no duplicate grant.
